// File: rtl/axi_sram_slave_pkg.sv
// Shared types and widths for the single-beat AXI SRAM responder.
// Holds channel widths, AXI response codes, FSM state encodings and
// the write-response decode helper.
package axi_sram_slave_pkg;

    localparam int ID_W       = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;
    localparam int RESP_W     = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_READ = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_WRITE = 2'd1,
        W_RESP  = 2'd2
    } wr_state_e;

    // An out-of-window address outranks an ID mismatch; neither writes.
    function automatic logic [RESP_W-1:0] write_resp(input logic dec_err,
                                                     input logic id_mismatch);
        if (dec_err)
            return RESP_DECERR;
        else if (id_mismatch)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sram_stall_lfsr.sv
// Pseudo-random ready-stall generator for the AXI SRAM responder.
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5.
// stall_o is high whenever the two low LFSR bits are both set.
module axi_sram_stall_lfsr (
    input  logic clk_i,
    input  logic rst_i,
    output logic stall_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next LFSR value: shift left, feedback from the polynomial taps.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR register, advancing every cycle once out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            lfsr_q <= 8'hA5;
        else
            lfsr_q <= lfsr_d;
    end

    assign stall_o = (lfsr_q[1:0] == 2'b11);

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI responder backed by a byte-writable 32-bit SRAM.
// Independent read and write FSMs, one outstanding transfer each.
// Optional feature macro: AXI_SRAM_STALL_EN -- when defined, an LFSR
// randomly drops arready/awready/wready to exercise initiator backpressure.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_W-1:0]       arid,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [RESP_W-1:0]     rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ID_W-1:0]       awid,
    input  logic [AXI_ADDR_W-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_W-1:0]       wid,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_W-1:0]       bid,
    output logic [RESP_W-1:0]     bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int DEPTH = 1 << ADDR_W;

    logic stall;

`ifdef AXI_SRAM_STALL_EN
    axi_sram_stall_lfsr u_stall (
        .clk_i   (aclk),
        .rst_i   (areset),
        .stall_o (stall)
    );
`else
    assign stall = 1'b0;
`endif

    // Byte lanes below the word boundary do not select anything.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{araddr[1:0], awaddr[1:0]};

    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_e         r_state_q, r_state_d;
    logic [ADDR_W-1:0] r_idx_q;
    logic              r_err_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [RESP_W-1:0] rresp_q;
    logic              ar_hs;

    assign arready = ~areset & ~stall & (r_state_q == R_IDLE);
    assign ar_hs   = arvalid & arready;

    // Read FSM next-state: accept, one registered array read, then hold R.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs)  r_state_d = R_READ;
            R_READ:              r_state_d = R_RESP;
            R_RESP:  if (rready) r_state_d = R_IDLE;
            default:             r_state_d = R_IDLE;
        endcase
    end

    // Read state, echoed ID and registered read data with response code.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs)
                rid_q <= arid;
            if (r_state_q == R_READ) begin
                rdata_q <= r_err_q ? '0 : mem[r_idx_q];
                rresp_q <= r_err_q ? RESP_DECERR : RESP_OKAY;
            end
        end
    end

    // Captured read word index and out-of-window flag at AR handshake.
    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            r_idx_q <= araddr[ADDR_W+1:2];
            r_err_q <= |araddr[AXI_ADDR_W-1:ADDR_W+2];
        end
    end

    assign rvalid = (r_state_q == R_RESP);
    assign rlast  = rvalid;
    assign rid    = rid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_e         w_state_q, w_state_d;
    logic              aw_have_q;
    logic              w_have_q;
    logic [ADDR_W-1:0] w_idx_q;
    logic              w_err_q;
    logic [ID_W-1:0]   awid_q;
    logic [ID_W-1:0]   wid_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [ID_W-1:0]   bid_q;
    logic [RESP_W-1:0] bresp_q;
    logic [RESP_W-1:0] wr_resp;
    logic              aw_hs;
    logic              w_hs;

    assign awready = ~areset & ~stall & (w_state_q == W_IDLE) & ~aw_have_q;
    assign wready  = ~areset & ~stall & (w_state_q == W_IDLE) & ~w_have_q;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign wr_resp = write_resp(w_err_q, wid_q != awid_q);

    // Write FSM next-state: leave idle once both AW and W are held.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if ((aw_have_q | aw_hs) && (w_have_q | w_hs))
                         w_state_d = W_WRITE;
            W_WRITE:     w_state_d = W_RESP;
            W_RESP:  if (bready)
                         w_state_d = W_IDLE;
            default:     w_state_d = W_IDLE;
        endcase
    end

    // Write state, channel-held flags and the B payload.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs)
                aw_have_q <= 1'b1;
            if (w_hs)
                w_have_q <= 1'b1;
            if (w_state_q == W_WRITE) begin
                aw_have_q <= 1'b0;
                w_have_q  <= 1'b0;
                bid_q     <= awid_q;
                bresp_q   <= wr_resp;
            end
        end
    end

    // Captured AW and W payloads, each latched on its own handshake.
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            awid_q  <= awid;
            w_idx_q <= awaddr[ADDR_W+1:2];
            w_err_q <= |awaddr[AXI_ADDR_W-1:ADDR_W+2];
        end
        if (w_hs) begin
            wid_q   <= wid;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    // Strobed array write; only an in-range, ID-consistent write commits.
    always_ff @(posedge aclk) begin
        if (!areset && (w_state_q == W_WRITE) && (wr_resp == RESP_OKAY)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b])
                    mem[w_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign bvalid = (w_state_q == W_RESP);
    assign bid    = bid_q;
    assign bresp  = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave (default build, no stall LFSR).
module tb_axi_sram_slave;

    logic        aclk;
    logic        areset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks   = 0;
    int failures = 0;

    axi_sram_slave dut (
        .aclk    (aclk),
        .areset  (areset),
        .arid    (arid),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready),
        .awid    (awid),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wid     (wid),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] id_aw,
                             input logic [3:0] id_w, output logic [1:0] resp,
                             output logic [3:0] id_b, output int lat);
        bit aw_ok, w_ok, aw_now, w_now;
        int n;
        awaddr = addr; awid = id_aw; wdata = data; wstrb = strb; wid = id_w;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_ok = 0; w_ok = 0; n = 0;
        while (!(aw_ok && w_ok) && n < 50) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            tick();
            n++;
            if (aw_now) begin aw_ok = 1; awvalid = 1'b0; end
            if (w_now)  begin w_ok = 1;  wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 1;
        while (!bvalid && lat < 50) begin
            tick();
            lat++;
        end
        resp = bresp;
        id_b = bid;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id,
                            output logic [31:0] data, output logic [1:0] resp,
                            output logic [3:0] id_r, output logic last, output int lat);
        bit hs;
        int n;
        araddr = addr; arid = id; arvalid = 1'b1; rready = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < 50) begin
            hs = arvalid && arready;
            tick();
            n++;
        end
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin
            tick();
            lat++;
        end
        data = rdata; resp = rresp; id_r = rid; last = rlast;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  rs;
        logic [3:0]  id;
        logic        last;
        int          lat;
        int          nb;
        logic [3:0]  seen_bid;

        areset = 1'b1;
        arid = '0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready",  {31'd0, wready},  32'd0);
        chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst_rlast",   {31'd0, rlast},   32'd0);
        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_payload", {rid, bid, rresp, bresp}, 32'd0);
        chk("rst_rdata",   rdata, 32'd0);

        areset = 1'b0;
        #1;
        chk("rel_readies", {29'd0, arready, awready, wready}, 32'd7);

        // Full-word write then read
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 4'd1, 4'd1, rs, id, lat);
        chk("w1_bresp", {30'd0, rs}, 32'd0);
        chk("w1_bid",   {28'd0, id}, 32'd1);
        chk("w1_lat",   lat, 32'd2);
        axi_read(32'h10, 4'd1, d, rs, id, last, lat);
        chk("r1_data",  d, 32'hDEADBEEF);
        chk("r1_rid",   {28'd0, id}, 32'd1);
        chk("r1_rresp", {30'd0, rs}, 32'd0);
        chk("r1_rlast", {31'd0, last}, 32'd1);
        chk("r1_lat",   lat, 32'd2);

        // Partial strobe write
        axi_write(32'h10, 32'h12345678, 4'b0011, 4'd3, 4'd3, rs, id, lat);
        chk("w2_bresp", {30'd0, rs}, 32'd0);
        axi_read(32'h13, 4'd2, d, rs, id, last, lat);
        chk("r2_data", d, 32'hDEAD5678);
        chk("r2_rid",  {28'd0, id}, 32'd2);

        // rready held low for 5 cycles
        araddr = 32'h10; arid = 4'd9; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_rvalid",  {31'd0, rvalid}, 32'd1);
            chk("hold_rdata",   rdata, 32'hDEAD5678);
            chk("hold_rid",     {28'd0, rid}, 32'd9);
            chk("hold_arready", {31'd0, arready}, 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("hold_done_rvalid",  {31'd0, rvalid}, 32'd0);
        chk("hold_done_arready", {31'd0, arready}, 32'd1);

        // W three cycles ahead of AW
        awaddr = 32'h20; awid = 4'd5; wid = 4'd5; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("wfirst_wready", {31'd0, wready}, 32'd0);
        tick();
        chk("wfirst_bvalid", {31'd0, bvalid}, 32'd0);
        tick();
        awvalid = 1'b1;
        chk("wfirst_awready", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        bready = 1'b1;
        nb = 0; seen_bid = '0;
        for (int i = 0; i < 8; i++) begin
            if (bvalid) begin nb++; seen_bid = bid; end
            tick();
        end
        bready = 1'b0;
        chk("wfirst_bcount", nb, 32'd1);
        chk("wfirst_bid", {28'd0, seen_bid}, 32'd5);
        axi_read(32'h20, 4'd5, d, rs, id, last, lat);
        chk("wfirst_data", d, 32'hCAFEF00D);

        // Decode errors
        axi_write(32'h0, 32'h0BADC0DE, 4'hF, 4'd1, 4'd1, rs, id, lat);
        axi_read(32'h00010000, 4'd4, d, rs, id, last, lat);
        chk("dec_rresp", {30'd0, rs}, 32'd3);
        chk("dec_rdata", d, 32'd0);
        axi_write(32'h00010000, 32'h11111111, 4'hF, 4'd1, 4'd1, rs, id, lat);
        chk("dec_bresp", {30'd0, rs}, 32'd3);
        axi_read(32'h0, 4'd4, d, rs, id, last, lat);
        chk("dec_word0", d, 32'h0BADC0DE);

        // ID mismatch
        axi_write(32'h10, 32'hFFFFFFFF, 4'hF, 4'd1, 4'd2, rs, id, lat);
        chk("slv_bresp", {30'd0, rs}, 32'd2);
        chk("slv_bid",   {28'd0, id}, 32'd1);
        axi_read(32'h10, 4'd1, d, rs, id, last, lat);
        chk("slv_nowrite", d, 32'hDEAD5678);

        // Same-word read and write in the same cycle: read-first
        awaddr = 32'h10; awid = 4'd2; wid = 4'd2; wdata = 32'h55AA55AA; wstrb = 4'hF;
        araddr = 32'h10; arid = 4'd7;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        chk("rf_rvalid", {31'd0, rvalid}, 32'd1);
        chk("rf_bvalid", {31'd0, bvalid}, 32'd1);
        chk("rf_old",    rdata, 32'hDEAD5678);
        chk("rf_rid",    {28'd0, rid}, 32'd7);
        chk("rf_bid",    {28'd0, bid}, 32'd2);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        axi_read(32'h10, 4'd7, d, rs, id, last, lat);
        chk("rf_new", d, 32'h55AA55AA);

        // Reset while holding a B response
        awaddr = 32'h30; awid = 4'd6; wid = 4'd6; wdata = 32'h77778888; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("wr_rst_bvalid_pre", {31'd0, bvalid}, 32'd1);
        areset = 1'b1;
        #1;
        chk("wr_rst_readies_in", {29'd0, arready, awready, wready}, 32'd0);
        tick();
        chk("wr_rst_bvalid", {31'd0, bvalid}, 32'd0);
        areset = 1'b0;
        #1;
        chk("wr_rst_readies_out", {29'd0, arready, awready, wready}, 32'd7);
        bready = 1'b1;
        nb = 0;
        for (int i = 0; i < 5; i++) begin
            if (bvalid) nb++;
            tick();
        end
        bready = 1'b0;
        chk("wr_rst_no_stale_b", nb, 32'd0);
        axi_read(32'h30, 4'd6, d, rs, id, last, lat);
        chk("wr_rst_persist", d, 32'h77778888);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
